mem_bus_initiator: RTL and testbench

Processor-side initiator for the tagged memory bus: the requesting end of the `proc2mem_*` / `mem2proc_*` protocol served by the `mem` model. It queues load/store requests from one client port, issues them on the bus, retries on refusal, tracks outstanding loads by the memory-assigned tag, and returns load data to the client with the client's request ID. It sits between the cache/LSU miss path and the external memory interface inside `processor`.

---
 rtl/mem_bus_initiator.sv | 195 +++++++++++++++++++
 tb/tb_mem_bus_initiator.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_initiator.sv
// ---------------------------------------------------------------------------
// mem_bus_initiator
//   Requesting end of the tagged proc2mem/mem2proc memory bus. Load and store
//   requests from one client port are queued, issued from the queue head,
//   reissued while the memory refuses them, and tracked by the memory-assigned
//   tag. Load data comes back to the client together with the client's ID.
//
// Ports
//   clock, reset            : single clock; asynchronous active-low reset
//   req_valid/req_ready     : client request handshake (enqueue on both high)
//   req_is_store/addr/data/size/id : request fields
//   proc2mem_command/addr/data/size : bus command (0 none, 1 load, 2 store)
//   mem2proc_response       : nonzero = command accepted with this tag
//   mem2proc_data/tag       : nonzero tag = load with that tag has completed
//   resp_valid/id/data      : one-cycle load response to the client
//   outstanding             : number of loads accepted and not yet completed
//   spurious_tag            : sticky protocol error flag
// ---------------------------------------------------------------------------
module mem_bus_initiator #(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 8,
   parameter int ID_W    = 3
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_is_store,
   input  logic [XLEN-1:0] req_addr,
   input  logic [63:0]     req_data,
   input  logic [1:0]      req_size,
   input  logic [ID_W-1:0] req_id,
   output logic [1:0]      proc2mem_command,
   output logic [XLEN-1:0] proc2mem_addr,
   output logic [63:0]     proc2mem_data,
   output logic [1:0]      proc2mem_size,
   input  logic [3:0]      mem2proc_response,
   input  logic [63:0]     mem2proc_data,
   input  logic [3:0]      mem2proc_tag,
   output logic            resp_valid,
   output logic [ID_W-1:0] resp_id,
   output logic [63:0]     resp_data,
   output logic [3:0]      outstanding,
   output logic            spurious_tag
);

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   localparam int               PTR_W     = $clog2(DEPTH);
   localparam int               CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [3:0]       MAX_OUT_C = 4'(MAX_OUT);

   // ---------------- request FIFO ----------------
   logic                  r_fifo_is_store [DEPTH];
   logic [XLEN-1:0]       r_fifo_addr     [DEPTH];
   logic [63:0]           r_fifo_data     [DEPTH];
   logic [1:0]            r_fifo_size     [DEPTH];
   logic [ID_W-1:0]       r_fifo_id       [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   // ---------------- tag table / status ----------------
   logic [15:0]           r_tag_valid;
   logic [ID_W-1:0]       r_tag_id [16];
   logic [3:0]            r_outstanding;
   logic                  r_resp_valid;
   logic [ID_W-1:0]       r_resp_id;
   logic [63:0]           r_resp_data;
   logic                  r_spurious;

   logic                  w_push;
   logic                  w_fifo_empty;
   logic                  w_head_is_store;
   logic [ID_W-1:0]       w_head_id;
   logic                  w_load_blocked;
   logic                  w_issue;
   logic                  w_accept;
   logic                  w_accept_load;
   logic                  w_cpl_hit;
   logic                  w_cpl_spurious;
   logic                  w_tag_reuse;
   logic                  w_accept_dup;

   assign req_ready       = (r_count < DEPTH_C);
   assign w_push          = req_valid && req_ready;
   assign w_fifo_empty    = (r_count == '0);
   assign w_head_is_store = r_fifo_is_store[r_rd_ptr];
   assign w_head_id       = r_fifo_id[r_rd_ptr];

   // A load at the head waits while the tag budget is exhausted; a store never does.
   assign w_load_blocked  = !w_head_is_store && (r_outstanding == MAX_OUT_C);
   assign w_issue         = !w_fifo_empty && !w_load_blocked;
   assign w_accept        = w_issue && (mem2proc_response != 4'd0);
   assign w_accept_load   = w_accept && !w_head_is_store;

   assign w_cpl_hit       = (mem2proc_tag != 4'd0) &&  r_tag_valid[mem2proc_tag];
   assign w_cpl_spurious  = (mem2proc_tag != 4'd0) && !r_tag_valid[mem2proc_tag];
   // Memory may hand back a tag in the same cycle it retires it; that is legal.
   assign w_tag_reuse     = w_cpl_hit && (mem2proc_tag == mem2proc_response);
   assign w_accept_dup    = w_accept_load && r_tag_valid[mem2proc_response] && !w_tag_reuse;

   // NOTE: the FIFO storage has no reset; validity is carried by r_count alone,
   // so stale contents are never observed and the array maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_is_store[r_wr_ptr] <= req_is_store;
         r_fifo_addr[r_wr_ptr]     <= req_addr;
         r_fifo_data[r_wr_ptr]     <= req_data;
         r_fifo_size[r_wr_ptr]     <= req_size;
         r_fifo_id[r_wr_ptr]       <= req_id;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_accept) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_accept})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: every output gets a default before the conditional drive, so no
   // latch is inferred and an idle bus reads all zeros.
   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      proc2mem_size    = '0;
      if (w_issue) begin
         proc2mem_command = w_head_is_store ? BUS_STORE : BUS_LOAD;
         proc2mem_addr    = r_fifo_addr[r_rd_ptr];
         proc2mem_data    = r_fifo_data[r_rd_ptr];
         proc2mem_size    = r_fifo_size[r_rd_ptr];
      end
   end

   // Completion clears first and acceptance writes second, so on a same-cycle
   // reuse of one tag the later assignment leaves the entry valid with the new ID.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tag_valid <= '0;
         for (int i = 0; i < 16; i++) r_tag_id[i] <= '0;
      end else begin
         if (w_cpl_hit) r_tag_valid[mem2proc_tag] <= 1'b0;
         if (w_accept_load) begin
            r_tag_valid[mem2proc_response] <= 1'b1;
            r_tag_id[mem2proc_response]    <= w_head_id;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_outstanding <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_id     <= '0;
         r_resp_data   <= '0;
         r_spurious    <= 1'b0;
      end else begin
         case ({w_accept_load, w_cpl_hit})
            2'b10:   r_outstanding <= r_outstanding + 4'd1;
            2'b01:   r_outstanding <= r_outstanding - 4'd1;
            default: r_outstanding <= r_outstanding;
         endcase
         r_resp_valid <= w_cpl_hit;
         if (w_cpl_hit) begin
            r_resp_id   <= r_tag_id[mem2proc_tag];
            r_resp_data <= mem2proc_data;
         end
         if (w_cpl_spurious || w_accept_dup) r_spurious <= 1'b1;
      end
   end

   assign resp_valid   = r_resp_valid;
   assign resp_id      = r_resp_id;
   assign resp_data    = r_resp_data;
   assign outstanding  = r_outstanding;
   assign spurious_tag = r_spurious;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_initiator
//   Directed bench for mem_bus_initiator with default parameters. Inputs are
//   driven 1 time unit after each rising edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_mem_bus_initiator;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [31:0] req_addr;
   logic [63:0] req_data;
   logic [1:0]  req_size;
   logic [2:0]  req_id;
   logic [1:0]  proc2mem_command;
   logic [31:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [1:0]  proc2mem_size;
   logic [3:0]  mem2proc_response;
   logic [63:0] mem2proc_data;
   logic [3:0]  mem2proc_tag;
   logic        resp_valid;
   logic [2:0]  resp_id;
   logic [63:0] resp_data;
   logic [3:0]  outstanding;
   logic        spurious_tag;

   int total = 0;
   int bad   = 0;

   // out-of-order scenario: loads ids 1,2,3 with tags 1,2,3, stores in between
   logic        ooo_store [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [31:0] ooo_addr  [5] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
   logic [2:0]  ooo_id    [5] = '{3'd1, 3'd7, 3'd2, 3'd7, 3'd3};
   logic [3:0]  ooo_tag   [5] = '{4'd1, 4'd15, 4'd2, 4'd14, 4'd3};

   mem_bus_initiator dut (
      .clock             (clock),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_is_store      (req_is_store),
      .req_addr          (req_addr),
      .req_data          (req_data),
      .req_size          (req_size),
      .req_id            (req_id),
      .proc2mem_command  (proc2mem_command),
      .proc2mem_addr     (proc2mem_addr),
      .proc2mem_data     (proc2mem_data),
      .proc2mem_size     (proc2mem_size),
      .mem2proc_response (mem2proc_response),
      .mem2proc_data     (mem2proc_data),
      .mem2proc_tag      (mem2proc_tag),
      .resp_valid        (resp_valid),
      .resp_id           (resp_id),
      .resp_data         (resp_data),
      .outstanding       (outstanding),
      .spurious_tag      (spurious_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_req(input logic st, input logic [31:0] a, input logic [63:0] d,
                            input logic [2:0] id);
      req_valid    = 1'b1;
      req_is_store = st;
      req_addr     = a;
      req_data     = d;
      req_size     = 2'd3;
      req_id       = id;
   endtask

   task automatic enqueue(input logic st, input logic [31:0] a, input logic [63:0] d,
                          input logic [2:0] id);
      drive_req(st, a, d, id);
      step();
      req_valid = 1'b0;
   endtask

   // Present a completion for one cycle; the response is visible on return.
   task automatic complete(input logic [3:0] t, input logic [63:0] d);
      mem2proc_tag  = t;
      mem2proc_data = d;
      step();
      mem2proc_tag  = 4'd0;
   endtask

   task automatic check_resp(input string tag, input logic [2:0] id, input logic [63:0] d);
      check({tag, "_valid"}, 64'(resp_valid), 64'd1);
      check({tag, "_id"},    64'(resp_id),    64'(id));
      check({tag, "_data"},  resp_data,       d);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 64'(req_ready),        64'd1);
      check({tag, "_cmd"},   64'(proc2mem_command), 64'(BUS_NONE));
      check({tag, "_addr"},  64'(proc2mem_addr),    64'd0);
      check({tag, "_data"},  proc2mem_data,         64'd0);
      check({tag, "_size"},  64'(proc2mem_size),    64'd0);
      check({tag, "_rv"},    64'(resp_valid),       64'd0);
      check({tag, "_rid"},   64'(resp_id),          64'd0);
      check({tag, "_rdata"}, resp_data,             64'd0);
      check({tag, "_out"},   64'(outstanding),      64'd0);
      check({tag, "_spur"},  64'(spurious_tag),     64'd0);
   endtask

   initial begin
      reset = 1'b0;
      req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_data = '0;
      req_size = '0; req_id = '0;
      mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;

      // ---- reset state ----
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("rst");
      reset = 1'b1;
      step();

      // ---- single load: id 5 @0x100, tag 3 ----
      enqueue(1'b0, 32'h100, 64'd0, 3'd5);
      check("t1_cmd",  64'(proc2mem_command), 64'(BUS_LOAD));
      check("t1_addr", 64'(proc2mem_addr),    64'h100);
      check("t1_size", 64'(proc2mem_size),    64'd3);
      check("t1_out0", 64'(outstanding),      64'd0);
      mem2proc_response = 4'd3;
      step();
      mem2proc_response = 4'd0;
      check("t1_out1", 64'(outstanding),      64'd1);
      check("t1_idle", 64'(proc2mem_command), 64'(BUS_NONE));
      repeat (7) step();
      mem2proc_tag  = 4'd3;
      mem2proc_data = 64'hDEADBEEF_01234567;
      check("t1_rv_early", 64'(resp_valid), 64'd0);
      step();
      mem2proc_tag = 4'd0;
      check_resp("t1_resp", 3'd5, 64'hDEADBEEF_01234567);
      check("t1_out2", 64'(outstanding), 64'd0);
      step();
      check("t1_rv_pulse", 64'(resp_valid), 64'd0);

      // ---- retry: refused 3 cycles, accepted with tag 2 on the 4th ----
      enqueue(1'b0, 32'h200, 64'd0, 3'd2);
      for (int i = 0; i < 3; i++) begin
         check("t2_cmd_hold",  64'(proc2mem_command), 64'(BUS_LOAD));
         check("t2_addr_hold", 64'(proc2mem_addr),    64'h200);
         step();
      end
      check("t2_cmd_4th",  64'(proc2mem_command), 64'(BUS_LOAD));
      check("t2_addr_4th", 64'(proc2mem_addr),    64'h200);
      mem2proc_response = 4'd2;
      step();
      mem2proc_response = 4'd0;
      check("t2_popped", 64'(proc2mem_command), 64'(BUS_NONE));
      check("t2_out",    64'(outstanding),      64'd1);
      complete(4'd2, 64'h2222);
      check_resp("t2_resp", 3'd2, 64'h2222);
      check("t2_out0", 64'(outstanding), 64'd0);

      // ---- out-of-order returns with interleaved stores ----
      for (int i = 0; i < 5; i++) begin
         enqueue(ooo_store[i], ooo_addr[i], 64'hABC0 + 64'(i), ooo_id[i]);
         check("t3_cmd", 64'(proc2mem_command), ooo_store[i] ? 64'(BUS_STORE) : 64'(BUS_LOAD));
         check("t3_addr", 64'(proc2mem_addr), 64'(ooo_addr[i]));
         if (ooo_store[i]) check("t3_sdata", proc2mem_data, 64'hABC0 + 64'(i));
         mem2proc_response = ooo_tag[i];
         step();
         mem2proc_response = 4'd0;
         check("t3_no_resp", 64'(resp_valid), 64'd0);
      end
      check("t3_out3", 64'(outstanding), 64'd3);
      mem2proc_tag = 4'd3; mem2proc_data = 64'hA3;
      step();
      mem2proc_tag = 4'd1; mem2proc_data = 64'hA1;
      check_resp("t3_r3", 3'd3, 64'hA3);
      step();
      mem2proc_tag = 4'd2; mem2proc_data = 64'hA2;
      check_resp("t3_r1", 3'd1, 64'hA1);
      step();
      mem2proc_tag = 4'd0;
      check_resp("t3_r2", 3'd2, 64'hA2);
      check("t3_out0", 64'(outstanding), 64'd0);
      step();
      check("t3_rv_end", 64'(resp_valid),   64'd0);
      check("t3_spur",   64'(spurious_tag), 64'd0);

      // ---- FIFO full while memory refuses ----
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b0, 32'h1000 + 32'(4 * i), 64'd0, 3'(i + 1));
         check("t4_ready_fill", 64'(req_ready), 64'd1);
         step();
      end
      drive_req(1'b0, 32'h1010, 64'd0, 3'd5);
      for (int i = 0; i < 3; i++) begin
         check("t4_full",      64'(req_ready),     64'd0);
         check("t4_head_addr", 64'(proc2mem_addr), 64'h1000);
         if (i < 2) step();
      end
      mem2proc_response = 4'd1;
      step();
      req_valid = 1'b0;
      mem2proc_response = 4'd0;
      check("t4_ready_again", 64'(req_ready),   64'd1);
      check("t4_out1",        64'(outstanding), 64'd1);
      for (int i = 1; i < 4; i++) begin
         check("t4_b2b_addr", 64'(proc2mem_addr), 64'h1000 + 64'(4 * i));
         mem2proc_response = 4'(i + 1);
         step();
      end
      mem2proc_response = 4'd0;
      check("t4_empty", 64'(proc2mem_command), 64'(BUS_NONE));
      check("t4_out4",  64'(outstanding),      64'd4);

      // ---- MAX_OUT: fill to 8 outstanding, 9th load held ----
      for (int i = 0; i < 4; i++) enqueue(1'b0, 32'h2000 + 32'(4 * i), 64'd0, 3'(4 + i));
      for (int i = 0; i < 4; i++) begin
         check("t5_addr", 64'(proc2mem_addr), 64'h2000 + 64'(4 * i));
         mem2proc_response = 4'(5 + i);
         step();
      end
      mem2proc_response = 4'd0;
      check("t5_out8", 64'(outstanding), 64'd8);
      enqueue(1'b0, 32'h9000, 64'd0, 3'd6);
      check("t5_hold_cmd",  64'(proc2mem_command), 64'(BUS_NONE));
      check("t5_hold_addr", 64'(proc2mem_addr),    64'd0);
      step();
      check("t5_hold_cmd2", 64'(proc2mem_command), 64'(BUS_NONE));
      complete(4'd4, 64'h4444);
      check_resp("t5_r4", 3'd4, 64'h4444);
      check("t5_out7",     64'(outstanding),      64'd7);
      check("t5_rel_cmd",  64'(proc2mem_command), 64'(BUS_LOAD));
      check("t5_rel_addr", 64'(proc2mem_addr),    64'h9000);
      mem2proc_response = 4'd4;
      step();
      mem2proc_response = 4'd0;
      check("t5_out8b", 64'(outstanding), 64'd8);

      // ---- same-cycle completion and reacceptance of tag 4 ----
      enqueue(1'b0, 32'hA000, 64'd0, 3'd2);
      check("t6_hold", 64'(proc2mem_command), 64'(BUS_NONE));
      complete(4'd5, 64'h5555);
      check_resp("t6_r5", 3'd4, 64'h5555);
      check("t6_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
      mem2proc_response = 4'd4;
      mem2proc_tag      = 4'd4;
      mem2proc_data     = 64'h4040;
      step();
      mem2proc_response = 4'd0;
      mem2proc_tag      = 4'd0;
      check_resp("t6_old", 3'd6, 64'h4040);
      check("t6_out7", 64'(outstanding),  64'd7);
      check("t6_spur", 64'(spurious_tag), 64'd0);
      complete(4'd4, 64'h4141);
      check_resp("t6_new", 3'd2, 64'h4141);
      check("t6_out6", 64'(outstanding), 64'd6);

      // ---- unknown tag 9 ----
      complete(4'd9, 64'h9999);
      check("t7_spur",  64'(spurious_tag), 64'd1);
      check("t7_norv",  64'(resp_valid),   64'd0);
      check("t7_out6",  64'(outstanding),  64'd6);
      for (int i = 1; i <= 3; i++) begin
         complete(4'(i), 64'(i));
         check_resp("t7_drain", 3'(i), 64'(i));
      end
      check("t7_out3", 64'(outstanding), 64'd3);

      // ---- asynchronous reset with 3 loads outstanding and one queued ----
      enqueue(1'b0, 32'hB000, 64'd0, 3'd1);
      check("t8_pre_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("t8_async");
      repeat (2) step();
      reset = 1'b1;
      complete(4'd6, 64'h6666);
      check("t8_late_spur", 64'(spurious_tag),     64'd1);
      check("t8_late_norv", 64'(resp_valid),       64'd0);
      check("t8_late_out",  64'(outstanding),      64'd0);
      check("t8_late_cmd",  64'(proc2mem_command), 64'(BUS_NONE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
